uart_rx_fifo: RTL and testbench

//   Receive-side byte buffer directly downstream of the UART receiver.

---
 rtl/uart_rx_fifo.sv | 88 ++++++++
 tb/tb_uart_rx_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: drops bad-stop frames,
// queues good bytes, and hands them to the consumer on valid/ready.
module uart_rx_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_stop_bit,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [7:0]        frame_err_cnt,
    input  logic              clear_flags
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic full;
    logic pop;
    logic push;
    logic drop;
    logic ferr;

    assign full = (level == (ADDR_W+1)'(DEPTH));
    assign pop  = out_valid & out_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push = in_valid & in_stop_bit & (~full | pop);
    assign drop = in_valid & in_stop_bit & full & ~pop;
    assign ferr = in_valid & ~in_stop_bit;

    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            overflow      <= 1'b0;
            frame_err_cnt <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            // Set/increment events take priority over a same-cycle clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end

            if (ferr) begin
                if (clear_flags) begin
                    frame_err_cnt <= 8'd1;
                end else if (frame_err_cnt != 8'hFF) begin
                    frame_err_cnt <= frame_err_cnt + 8'd1;
                end
            end else if (clear_flags) begin
                frame_err_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic,
// compared each cycle against a queue-based model.
module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_stop_bit;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        level;
    logic              overflow;
    logic [7:0]        frame_err_cnt;
    logic              clear_flags;

    int checks = 0;
    int errors = 0;

    // Reference model state
    byte unsigned m_q[$];
    bit           m_ovf;
    int           m_cnt;

    uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_stop_bit   (in_stop_bit),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .level         (level),
        .overflow      (overflow),
        .frame_err_cnt (frame_err_cnt),
        .clear_flags   (clear_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock with the current inputs, update the model, compare.
    task automatic cycle();
        bit pop;
        bit push;
        pop  = (m_q.size() != 0) && out_ready;
        push = in_valid && in_stop_bit && (m_q.size() < DEPTH || pop);
        @(posedge clk);
        #1;
        if (reset) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(in_data);
            if (in_valid && in_stop_bit && !push) m_ovf = 1'b1;
            else if (clear_flags) m_ovf = 1'b0;
            if (in_valid && !in_stop_bit)
                m_cnt = clear_flags ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
            else if (clear_flags)
                m_cnt = 0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("level", 32'(level), 32'(m_q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_err_cnt", 32'(frame_err_cnt), 32'(m_cnt));
        if (m_q.size() != 0)
            chk("out_data", 32'(out_data), 32'(m_q[0]));
    endtask

    task automatic drive(input bit v, input byte unsigned d, input bit s,
                         input bit r, input bit c);
        reset       = 1'b0;
        in_valid    = v;
        in_data     = d;
        in_stop_bit = s;
        out_ready   = r;
        clear_flags = c;
        cycle();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_stop_bit = 1'b1;
        out_ready   = 1'b0;
        clear_flags = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 1; i <= DEPTH; i++) drive(1, byte'(i), 1, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) drive(0, 8'h00, 1, 1, 0);
    endtask

    initial begin
        in_data = '0;
        do_reset();
        do_reset();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);

        // Single push, consumer stalled
        drive(1, 8'hA5, 1, 0, 0);
        chk("t1_data", 32'(out_data), 32'hA5);
        chk("t1_level", 32'(level), 32'd1);
        drive(0, 8'h00, 1, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        chk("t1_hold", 32'(out_data), 32'hA5);

        // Fill and drain with pointer wrap
        do_reset();
        fill16();
        chk("t2_full", 32'(level), 32'd16);
        drain();
        chk("t2_empty", 32'(level), 32'd0);
        fill16();
        drain();

        // Overflow when full and not popping
        do_reset();
        fill16();
        drive(1, 8'h55, 1, 0, 0);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_level", 32'(level), 32'd16);
        chk("t3_head", 32'(out_data), 32'h01);
        drain();
        chk("t3_sticky", 32'(overflow), 32'd1);

        // Full with simultaneous pop accepts the push
        do_reset();
        fill16();
        drive(1, 8'h77, 1, 1, 0);
        chk("t4_level", 32'(level), 32'd16);
        chk("t4_ovf", 32'(overflow), 32'd0);
        drain();

        // Framing errors and clear collision
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 8'hE0, 0, 0, 0);
        chk("t5_cnt3", 32'(frame_err_cnt), 32'd3);
        drive(1, 8'hE1, 0, 0, 1);
        chk("t5_clr", 32'(frame_err_cnt), 32'd1);
        chk("t5_empty", 32'(out_valid), 32'd0);
        drive(0, 8'h00, 1, 0, 1);
        chk("t5_clr0", 32'(frame_err_cnt), 32'd0);

        // Saturation at 255
        for (int i = 0; i < 260; i++) drive(1, 8'hEE, 0, 0, 0);
        chk("sat", 32'(frame_err_cnt), 32'd255);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) drive(1, byte'(8'h20 + i), 1, 0, 0);
        do_reset();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        drive(1, 8'h3C, 1, 0, 0);
        chk("t6_head", 32'(out_data), 32'h3C);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias        = (i / 500) % 3;
            reset       = ($urandom_range(199) == 0);
            in_valid    = ($urandom_range(1) == 1);
            in_data     = 8'($urandom);
            in_stop_bit = ($urandom_range(9) != 0);
            out_ready   = ($urandom_range(3) < bias + 1);
            clear_flags = ($urandom_range(39) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
